// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one serial multiplier among N_REQ requesters,
// with a watchdog that aborts a stalled multiply and reports an error response.
module mult_arbiter #(
    parameter int NB_DATA     = 4,
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [N_REQ-1:0]           i_req_valid,
    input  logic [N_REQ*NB_DATA-1:0]   i_req_a,
    input  logic [N_REQ*NB_DATA-1:0]   i_req_b,
    output logic [N_REQ-1:0]           o_req_ready,
    output logic [N_REQ-1:0]           o_rsp_valid,
    output logic [NB_DATA-1:0]         o_rsp_data,
    output logic                       o_rsp_err,
    output logic                       o_mul_start,
    output logic [NB_DATA-1:0]         o_mul_a,
    output logic [NB_DATA-1:0]         o_mul_b,
    input  logic                       i_mul_done,
    input  logic [NB_DATA-1:0]         i_mul_result,
    output logic                       o_busy
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    typedef struct packed {
        logic [GW-1:0]      idx;
        logic [NB_DATA-1:0] a;
        logic [NB_DATA-1:0] b;
    } txn_t;

    state_t                          state;
    txn_t                            txn;
    logic [GW-1:0]                   last_grant;
    logic [CW-1:0]                   wd_cnt;
    logic [N_REQ-1:0][NB_DATA-1:0]   req_a;
    logic [N_REQ-1:0][NB_DATA-1:0]   req_b;
    logic [GW-1:0]                   grant;
    logic                            grant_vld;

    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign req_a[k] = i_req_a[k*NB_DATA +: NB_DATA];
        assign req_b[k] = i_req_b[k*NB_DATA +: NB_DATA];
    end

    // Scan from the farthest candidate to the nearest so the nearest valid
    // index after last_grant is the one left standing.
    always_comb begin
        int cand;
        cand      = 0;
        grant     = '0;
        grant_vld = 1'b0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = int'(last_grant) + i;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (i_req_valid[cand]) begin
                grant     = GW'(cand);
                grant_vld = 1'b1;
            end
        end
    end

    assign o_req_ready = (state == IDLE && grant_vld) ? (N_REQ'(1) << grant) : '0;
    assign o_mul_a     = txn.a;
    assign o_mul_b     = txn.b;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            txn         <= '0;
            last_grant  <= GW'(N_REQ - 1);
            wd_cnt      <= '0;
            o_mul_start <= 1'b0;
            o_rsp_valid <= '0;
            o_rsp_data  <= '0;
            o_rsp_err   <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_mul_start <= 1'b0;
            o_rsp_valid <= '0;
            o_rsp_data  <= '0;
            o_rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        txn         <= '{idx: grant, a: req_a[grant], b: req_b[grant]};
                        o_mul_start <= 1'b1;
                        o_busy      <= 1'b1;
                        state       <= START;
                    end
                end
                START: begin
                    wd_cnt <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    // wd_cnt holds the number of WAIT cycles already elapsed
                    if (i_mul_done) begin
                        o_rsp_valid <= N_REQ'(1) << txn.idx;
                        o_rsp_data  <= i_mul_result;
                        state       <= RESP;
                    end else if (wd_cnt == CW'(TIMEOUT_CYC - 1)) begin
                        o_rsp_valid <= N_REQ'(1) << txn.idx;
                        o_rsp_err   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                RESP: begin
                    last_grant <= txn.idx;
                    o_busy     <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
